// File: rtl/knn_stream_engine.sv
// Streaming k-nearest-neighbour engine: input register, distance stage and sorted K-entry insert.
// Define KNN_VOTE_EN to build the majority-vote stage (VOTE state, class_label/class_valid).
module knn_stream_engine #(
  parameter int  COORD_W = 16,
  parameter int  K       = 4,
  parameter int  LABEL_W = 8,
  localparam int DIST_W  = 2*COORD_W+3,
  localparam int CNT_W   = $clog2(K+1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [2*COORD_W-1:0]   i_test_point,
  input  logic                   i_data_valid,
  output logic                   o_data_ready,
  input  logic [2*COORD_W-1:0]   i_data_point,
  input  logic [LABEL_W-1:0]     i_data_label,
  input  logic                   i_data_last,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [K*DIST_W-1:0]    o_nb_dist,
  output logic [K*LABEL_W-1:0]   o_nb_label,
  output logic [CNT_W-1:0]       o_nb_count,
  output logic [LABEL_W-1:0]     o_class_label,
  output logic                   o_class_valid,
  output logic [2:0]             o_state
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_VOTE, S_DONE} state_t;

  state_t                r_state;
  logic                  r_data_ready;
  logic                  r_busy;
  logic                  r_done;
  logic [2*COORD_W-1:0]  r_test_point;

  logic                  r_in_valid;
  logic [2*COORD_W-1:0]  r_in_point;
  logic [LABEL_W-1:0]    r_in_label;
  logic                  r_s1_valid;
  logic [DIST_W-1:0]     r_s1_dist;
  logic [LABEL_W-1:0]    r_s1_label;

  logic [DIST_W-1:0]     r_nb_dist  [K];
  logic [LABEL_W-1:0]    r_nb_label [K];
  logic [CNT_W-1:0]      r_nb_count;

  logic                  w_start_acc;
  logic                  w_accept;
  logic signed [COORD_W:0]     w_dx, w_dy;
  logic signed [2*COORD_W+1:0] w_dx_ext, w_dy_ext, w_dx2, w_dy2;
  logic [DIST_W-1:0]     w_dist;
  logic [K-1:0]          w_le;
  logic [K:0]            w_le_ext;
  logic [DIST_W-1:0]     w_up_dist  [K];
  logic [LABEL_W-1:0]    w_up_label [K];
  logic [DIST_W-1:0]     w_nxt_dist [K];
  logic [LABEL_W-1:0]    w_nxt_label[K];

  // Handshake: a point transfers on a rising edge where i_data_valid and o_data_ready are both 1;
  // o_data_ready is a registered function of state only, and i_data_valid is ignored while it is 0.
  assign w_start_acc = (r_state == S_IDLE) && i_start;
  assign w_accept    = r_data_ready && i_data_valid;

  // Sign-extended differences; squares are non-negative so the sum fits DIST_W unsigned.
  assign w_dx = $signed({r_in_point[COORD_W-1], r_in_point[COORD_W-1:0]})
              - $signed({r_test_point[COORD_W-1], r_test_point[COORD_W-1:0]});
  assign w_dy = $signed({r_in_point[2*COORD_W-1], r_in_point[2*COORD_W-1:COORD_W]})
              - $signed({r_test_point[2*COORD_W-1], r_test_point[2*COORD_W-1:COORD_W]});
  assign w_dx_ext = (2*COORD_W+2)'(w_dx);
  assign w_dy_ext = (2*COORD_W+2)'(w_dy);
  assign w_dx2    = w_dx_ext * w_dx_ext;
  assign w_dy2    = w_dy_ext * w_dy_ext;
  assign w_dist   = {1'b0, w_dx2} + {1'b0, w_dy2};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_valid <= 1'b0;
      r_in_point <= '0;
      r_in_label <= '0;
      r_s1_valid <= 1'b0;
      r_s1_dist  <= '0;
      r_s1_label <= '0;
    end else begin
      r_in_valid <= w_accept;
      if (w_accept) begin
        r_in_point <= i_data_point;
        r_in_label <= i_data_label;
      end
      r_s1_valid <= r_in_valid;
      if (r_in_valid) begin
        r_s1_dist  <= w_dist;
        r_s1_label <= r_in_label;
      end
    end
  end

  // w_le is a prefix mask (list is sorted); the new entry lands on the first slot not <= dist,
  // which keeps equal distances in arrival order and discards when every slot is <= dist.
  always_comb begin
    for (int j = 0; j < K; j++)
      w_le[j] = (CNT_W'(j) < r_nb_count) && (r_nb_dist[j] <= r_s1_dist);
    w_le_ext = {w_le, 1'b1};
    w_up_dist[0]  = '0;
    w_up_label[0] = '0;
    for (int j = 1; j < K; j++) begin
      w_up_dist[j]  = r_nb_dist[j-1];
      w_up_label[j] = r_nb_label[j-1];
    end
    for (int j = 0; j < K; j++) begin
      if (w_le[j]) begin
        w_nxt_dist[j]  = r_nb_dist[j];
        w_nxt_label[j] = r_nb_label[j];
      end else if (w_le_ext[j]) begin
        w_nxt_dist[j]  = r_s1_dist;
        w_nxt_label[j] = r_s1_label;
      end else begin
        w_nxt_dist[j]  = w_up_dist[j];
        w_nxt_label[j] = w_up_label[j];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int j = 0; j < K; j++) begin
        r_nb_dist[j]  <= '1;
        r_nb_label[j] <= '0;
      end
      r_nb_count <= '0;
    end else if (w_start_acc) begin
      for (int j = 0; j < K; j++) begin
        r_nb_dist[j]  <= '1;
        r_nb_label[j] <= '0;
      end
      r_nb_count <= '0;
    end else if (r_s1_valid) begin
      for (int j = 0; j < K; j++) begin
        r_nb_dist[j]  <= w_nxt_dist[j];
        r_nb_label[j] <= w_nxt_label[j];
      end
      if (r_nb_count != CNT_W'(K))
        r_nb_count <= r_nb_count + CNT_W'(1);
    end
  end

`ifdef KNN_VOTE_EN
  logic [CNT_W-1:0]   r_vcnt;
  logic [CNT_W-1:0]   r_best_cnt;
  logic [LABEL_W-1:0] r_best_label;
  logic [LABEL_W-1:0] r_class_label;
  logic               r_class_valid;
  logic [LABEL_W-1:0] w_cur_label;
  logic [CNT_W-1:0]   w_vote_cnt;
  logic               w_take;

  // Strictly-greater replacement lets ties fall to the nearer neighbour's label.
  always_comb begin
    w_cur_label = '0;
    w_vote_cnt  = '0;
    for (int j = 0; j < K; j++)
      if (CNT_W'(j) == r_vcnt) w_cur_label = r_nb_label[j];
    for (int j = 0; j < K; j++)
      if ((CNT_W'(j) < r_nb_count) && (r_nb_label[j] == w_cur_label))
        w_vote_cnt = w_vote_cnt + CNT_W'(1);
    w_take = (r_vcnt < r_nb_count) && (w_vote_cnt > r_best_cnt);
  end

  assign o_class_label = r_class_label;
  assign o_class_valid = r_class_valid;
`else
  assign o_class_label = '0;
  assign o_class_valid = 1'b0;
`endif

  // DRAIN waits until both pipeline registers are empty, so the last insert is committed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_data_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_test_point <= '0;
`ifdef KNN_VOTE_EN
      r_vcnt        <= '0;
      r_best_cnt    <= '0;
      r_best_label  <= '0;
      r_class_label <= '0;
      r_class_valid <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_test_point <= i_test_point;
            r_state      <= S_RUN;
            r_data_ready <= 1'b1;
            r_busy       <= 1'b1;
`ifdef KNN_VOTE_EN
            r_class_valid <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (i_data_valid && i_data_last) begin
            r_state      <= S_DRAIN;
            r_data_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!r_in_valid && !r_s1_valid) begin
`ifdef KNN_VOTE_EN
            r_state      <= S_VOTE;
            r_vcnt       <= '0;
            r_best_cnt   <= '0;
            r_best_label <= '0;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef KNN_VOTE_EN
        S_VOTE: begin
          if (w_take) begin
            r_best_cnt   <= w_vote_cnt;
            r_best_label <= w_cur_label;
          end
          if (r_vcnt == CNT_W'(K-1)) begin
            r_state       <= S_DONE;
            r_done        <= 1'b1;
            r_class_valid <= 1'b1;
            r_class_label <= w_take ? w_cur_label : r_best_label;
          end else begin
            r_vcnt <= r_vcnt + CNT_W'(1);
          end
        end
`endif
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < K; j++) begin
      o_nb_dist[j*DIST_W +: DIST_W]    = r_nb_dist[j];
      o_nb_label[j*LABEL_W +: LABEL_W] = r_nb_label[j];
    end
  end

  assign o_nb_count   = r_nb_count;
  assign o_data_ready = r_data_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_state      = r_state;

endmodule
